dram_resp: RTL and testbench

//  DRAM-side responder for the accelerator's single-port memory master (conv, pool, fc).

---
 rtl/accel_pkg.sv | 10 +
 rtl/dram_resp_if.sv | 30 +++
 rtl/dram_array.sv | 31 +++
 rtl/dram_resp.sv | 86 ++++++++
 tb/tb_dram_resp.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// Constants shared by the accelerator masters and the DRAM responder.
// Also holds the address range check used on every port.
package accel_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 18;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr, input int unsigned depth);
    return 32'(addr) < depth;
  endfunction
endpackage

// File: rtl/dram_resp_if.sv
// Master request/response bus plus the side load port of the DRAM responder.
interface dram_resp_if;
  import accel_pkg::*;

  logic                  dram_en_rd;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  dram_en_wr;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  dram_valid;
  logic                  ld_en;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic [DATA_WIDTH-1:0] ld_rdata;
  logic                  oob_err;

  modport slave (
    input  dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
    input  ld_en, ld_we, ld_addr, ld_wdata,
    output data_in, dram_valid, ld_rdata, oob_err
  );

  modport master (
    output dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
    output ld_en, ld_we, ld_addr, ld_wdata,
    input  data_in, dram_valid, ld_rdata, oob_err
  );
endinterface

// File: rtl/dram_array.sv
// Word array with two write ports (master has priority) and two asynchronous read ports.
// Plain register array; can be swapped for an SRAM macro with the same port behaviour.
module dram_array
  import accel_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  m_we,
  input  logic [IDX_W-1:0]      m_widx,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  s_we,
  input  logic [IDX_W-1:0]      s_widx,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [IDX_W-1:0]      m_ridx,
  input  logic [IDX_W-1:0]      s_ridx,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [DATA_WIDTH-1:0] s_rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents deliberately have no reset so they survive a block reset.
  always_ff @(posedge clk) begin
    if (m_we) mem[m_widx] <= m_wdata;
    if (s_we && !(m_we && m_widx == s_widx)) mem[s_widx] <= s_wdata;
  end

  assign m_rdata = mem[m_ridx];
  assign s_rdata = mem[s_ridx];
endmodule

// File: rtl/dram_resp.sv
// DRAM-side responder: serves master reads/writes against an on-chip array with a fixed
// read latency, plus a side load port for preload and readback.
module dram_resp
  import accel_pkg::*;
#(
  parameter int MEM_DEPTH = 4096,
  parameter int RD_LAT    = 2
) (
  input logic       clk,
  input logic       rst,
  dram_resp_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic                  rd_ok, wr_ok, ld_ok;
  logic                  m_we, s_we;
  logic [DATA_WIDTH-1:0] m_rdata, s_rdata, rd_data;
  logic [RD_LAT-1:0]     vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LAT];
  logic [DATA_WIDTH-1:0] ld_rdata_q;
  logic                  oob_q;

  assign rd_ok = in_range(bus.addr_in, MEM_DEPTH);
  assign wr_ok = in_range(bus.addr_out, MEM_DEPTH);
  assign ld_ok = in_range(bus.ld_addr, MEM_DEPTH);
  assign m_we  = bus.dram_en_wr && wr_ok;
  assign s_we  = bus.ld_en && bus.ld_we && ld_ok;

  dram_array #(.DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .m_we    (m_we),
    .m_widx  (bus.addr_out[IDX_W-1:0]),
    .m_wdata (bus.data_out),
    .s_we    (s_we),
    .s_widx  (bus.ld_addr[IDX_W-1:0]),
    .s_wdata (bus.ld_wdata),
    .m_ridx  (bus.addr_in[IDX_W-1:0]),
    .s_ridx  (bus.ld_addr[IDX_W-1:0]),
    .m_rdata (m_rdata),
    .s_rdata (s_rdata)
  );

  // Write-first: a same-cycle master write to the read address bypasses the array.
  always_comb begin
    rd_data = m_rdata;
    if (!rd_ok)                                 rd_data = '0;
    else if (m_we && bus.addr_out == bus.addr_in) rd_data = bus.data_out;
  end

  // Data stages only advance behind a valid so data_in holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= bus.dram_en_rd;
      if (bus.dram_en_rd) dat_q[0] <= rd_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_rdata_q <= '0;
    end else if (bus.ld_en && !bus.ld_we) begin
      ld_rdata_q <= ld_ok ? s_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_q <= 1'b0;
    end else if ((bus.dram_en_rd && !rd_ok) || (bus.dram_en_wr && !wr_ok) ||
                 (bus.ld_en && !ld_ok)) begin
      oob_q <= 1'b1;
    end
  end

  assign bus.data_in    = dat_q[RD_LAT-1];
  assign bus.dram_valid = vld_q[RD_LAT-1];
  assign bus.ld_rdata   = ld_rdata_q;
  assign bus.oob_err    = oob_q;
endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp: table of per-cycle vectors plus hand sequences for
// streaming reads and reset during in-flight reads.
module tb_dram_resp;
  import accel_pkg::*;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4096;
  localparam int NVEC   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  dram_resp_if bus ();

  dram_resp #(.MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  rd;
    logic [ADDR_WIDTH-1:0] ra;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;
    logic                  ld;
    logic                  lwe;
    logic [ADDR_WIDTH-1:0] la;
    logic [DATA_WIDTH-1:0] lwd;
    logic                  ev;
    logic [DATA_WIDTH-1:0] ed;
    logic [DATA_WIDTH-1:0] el;
    logic                  eo;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rd, input int ra, input logic wr, input int wa,
                              input logic [31:0] wd, input logic ld, input logic lwe,
                              input int la, input logic [31:0] lwd, input logic ev,
                              input logic [31:0] ed, input logic [31:0] el, input logic eo);
    vec_t v;
    v.rd = rd; v.ra = ADDR_WIDTH'(ra); v.wr = wr; v.wa = ADDR_WIDTH'(wa); v.wd = wd;
    v.ld = ld; v.lwe = lwe; v.la = ADDR_WIDTH'(la); v.lwd = lwd;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dram_en_rd = 1'b0; bus.addr_in  = '0;
    bus.dram_en_wr = 1'b0; bus.addr_out = '0; bus.data_out = '0;
    bus.ld_en = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
  endtask

  task automatic apply(input vec_t v);
    bus.dram_en_rd = v.rd;  bus.addr_in  = v.ra;
    bus.dram_en_wr = v.wr;  bus.addr_out = v.wa; bus.data_out = v.wd;
    bus.ld_en = v.ld; bus.ld_we = v.lwe; bus.ld_addr = v.la; bus.ld_wdata = v.lwd;
  endtask

  initial begin
    // Table expectations assume RD_LAT=2: a read in vector k emerges after vector k+1.
    vecs[0]  = mk(0, 0,    0, 0,    0,            1, 1, 5,    32'hDEADBEEF, 0, 24,           0,      0);
    vecs[1]  = mk(1, 5,    0, 0,    0,            0, 0, 0,    0,            0, 24,           0,      0);
    vecs[2]  = mk(0, 0,    0, 0,    0,            0, 0, 0,    0,            1, 32'hDEADBEEF, 0,      0);
    vecs[3]  = mk(0, 0,    0, 0,    0,            0, 0, 0,    0,            0, 32'hDEADBEEF, 0,      0);
    vecs[4]  = mk(1, 7,    1, 7,    32'h1234,     1, 0, 7,    0,            0, 32'hDEADBEEF, 7,      0);
    vecs[5]  = mk(1, 7,    0, 0,    0,            1, 0, 7,    0,            1, 32'h1234,     32'h1234, 0);
    vecs[6]  = mk(0, 0,    0, 0,    0,            0, 0, 0,    0,            1, 32'h1234,     32'h1234, 0);
    vecs[7]  = mk(0, 0,    1, 9,    32'hBBBB,     1, 1, 9,    32'hAAAA,     0, 32'h1234,     32'h1234, 0);
    vecs[8]  = mk(0, 0,    1, 11,   32'h6666,     1, 0, 9,    0,            0, 32'h1234,     32'hBBBB, 0);
    vecs[9]  = mk(0, 0,    1, 12,   32'h7777,     1, 1, 10,   32'h5555,     0, 32'h1234,     32'hBBBB, 0);
    vecs[10] = mk(1, 10,   0, 0,    0,            1, 0, 12,   0,            0, 32'h1234,     32'h7777, 0);
    vecs[11] = mk(1, 11,   0, 0,    0,            0, 0, 0,    0,            1, 32'h5555,     32'h7777, 0);
    vecs[12] = mk(0, 0,    0, 0,    0,            0, 0, 0,    0,            1, 32'h6666,     32'h7777, 0);
    vecs[13] = mk(1, 4097, 0, 0,    0,            0, 0, 0,    0,            0, 32'h6666,     32'h7777, 1);
    vecs[14] = mk(0, 0,    1, 4096, 32'hFFFFFFFF, 0, 0, 0,    0,            1, 0,            32'h7777, 1);
    vecs[15] = mk(1, 0,    0, 0,    0,            0, 0, 0,    0,            0, 0,            32'h7777, 1);
    vecs[16] = mk(0, 0,    0, 0,    0,            1, 0, 4100, 0,            1, 0,            0,      1);
    vecs[17] = mk(1, 1,    0, 0,    0,            1, 1, 4097, 32'hCAFE,     0, 0,            0,      1);
    vecs[18] = mk(1, 1,    0, 0,    0,            0, 0, 0,    0,            1, 1,            0,      1);
    vecs[19] = mk(0, 0,    0, 0,    0,            0, 0, 0,    0,            1, 1,            0,      1);

    idle();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("idle_valid", 32'(bus.dram_valid), 0);
    check("idle_data",  bus.data_in, 0);
    check("idle_oob",   32'(bus.oob_err), 0);
    check("idle_ld",    bus.ld_rdata, 0);

    for (int a = 0; a < 25; a++) begin
      bus.ld_en = 1'b1; bus.ld_we = 1'b1;
      bus.ld_addr = ADDR_WIDTH'(a); bus.ld_wdata = 32'(a);
      step();
    end
    idle();

    for (int i = 0; i < 25 + RD_LAT; i++) begin
      int k;
      bus.dram_en_rd = (i < 25);
      bus.addr_in    = ADDR_WIDTH'(i);
      step();
      k = i - (RD_LAT - 1);
      check("stream_valid", 32'(bus.dram_valid), (k >= 0 && k < 25) ? 1 : 0);
      if (k >= 0 && k < 25) check("stream_data", bus.data_in, 32'(k));
    end
    idle();

    for (int v = 0; v < NVEC; v++) begin
      apply(vecs[v]);
      step();
      check($sformatf("vec%0d_valid", v), 32'(bus.dram_valid), 32'(vecs[v].ev));
      check($sformatf("vec%0d_data", v),  bus.data_in,         vecs[v].ed);
      check($sformatf("vec%0d_ld", v),    bus.ld_rdata,        vecs[v].el);
      check($sformatf("vec%0d_oob", v),   32'(bus.oob_err),    32'(vecs[v].eo));
    end
    idle();

    // Two reads in flight, reset lands right after the first has emerged.
    bus.dram_en_rd = 1'b1; bus.addr_in = 18'd5;
    step();
    bus.addr_in = 18'd7;
    step();
    idle();
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.dram_valid), 0);
    check("rst_data",  bus.data_in, 0);
    check("rst_oob",   32'(bus.oob_err), 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_rst_valid", 32'(bus.dram_valid), 0);
    end

    bus.dram_en_rd = 1'b1; bus.addr_in = 18'd5;
    bus.ld_en = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 18'd24;
    step();
    idle();
    check("retain_ld", bus.ld_rdata, 24);
    check("retain_valid_early", 32'(bus.dram_valid), 0);
    step();
    check("retain_valid", 32'(bus.dram_valid), 1);
    check("retain_data",  bus.data_in, 32'hDEADBEEF);
    step();
    check("retain_pulse_end", 32'(bus.dram_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
